// File: rtl/axis_input_scheduler.sv
// axis_input_scheduler
//   Gates three upstream AXI-Stream handshakes (pixel 1, pixel 2, weight) into
//   an input pipe. Each iteration passes an exact number of beats per stream,
//   then waits for the pipe's last output beat, idles GAP_CYCLES, and repeats.
//   Only the handshakes pass through this block; the data does not.
// Ports:
//   aclk, aresetn                    clock, async active-low reset
//   start, cfg_*                     job request and config (used in IDLE only)
//   up_*_tvalid/tlast/tready         upstream side of each stream
//   dn_*_tvalid/tready               pipe side of each stream
//   m_axis_tvalid/tready/tlast       monitor of the pipe output
//   busy, done, itr, err             status; done is a pulse, err is sticky
module axis_input_scheduler #(
  parameter int BEATS_W    = 16,
  parameter int ITR_W      = 8,
  parameter int GAP_CYCLES = 100
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               cfg_is_max,
  input  logic [ITR_W-1:0]   cfg_iterations,
  input  logic [BEATS_W-1:0] cfg_beats_1,
  input  logic [BEATS_W-1:0] cfg_beats_w,
  input  logic               up_px1_tvalid,
  input  logic               up_px1_tlast,
  output logic               up_px1_tready,
  input  logic               up_px2_tvalid,
  input  logic               up_px2_tlast,
  output logic               up_px2_tready,
  input  logic               up_w_tvalid,
  input  logic               up_w_tlast,
  output logic               up_w_tready,
  output logic               dn_px1_tvalid,
  input  logic               dn_px1_tready,
  output logic               dn_px2_tvalid,
  input  logic               dn_px2_tready,
  output logic               dn_w_tvalid,
  input  logic               dn_w_tready,
  input  logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               m_axis_tlast,
  output logic               busy,
  output logic               done,
  output logic [ITR_W-1:0]   itr,
  output logic               err
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, GAP} state_t;
  state_t state, state_nxt;

  // Stream index: 0 = px1, 1 = px2, 2 = w
  logic [2:0]              en, upv, upl, dnr, acc, last, fin;
  logic [2:0][BEATS_W-1:0] cnt, beats;
  logic [ITR_W-1:0]        iterations;
  logic [GW-1:0]           gap_cnt;
  logic                    is_max, out_seen, out_hs, cfg_bad, gap_end, last_itr;
  logic                    go_feed, fin_job, px2_en;

  assign upv = {up_w_tvalid, up_px2_tvalid, up_px1_tvalid};
  assign upl = {up_w_tlast,  up_px2_tlast,  up_px1_tlast};
  assign dnr = {dn_w_tready, dn_px2_tready, dn_px1_tready};

  assign dn_px1_tvalid = up_px1_tvalid & en[0];
  assign dn_px2_tvalid = up_px2_tvalid & en[1];
  assign dn_w_tvalid   = up_w_tvalid   & en[2];
  assign up_px1_tready = dn_px1_tready & en[0];
  assign up_px2_tready = dn_px2_tready & en[1];
  assign up_w_tready   = dn_w_tready   & en[2];

  assign acc = upv & dnr & en;

  // A stream is finished once disabled, or when its final beat goes this cycle.
  always_comb begin
    last = '0;
    fin  = '0;
    for (int i = 0; i < 3; i++) begin
      last[i] = (cnt[i] == beats[i] - 1'b1);
      fin[i]  = ~en[i] | (acc[i] & last[i]);
    end
  end

  assign out_hs   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign cfg_bad  = (cfg_beats_1 == '0) | (cfg_beats_w == '0) |
                    (cfg_is_max & (cfg_beats_1 == BEATS_W'(1)));
  assign gap_end  = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign last_itr = (({1'b0, itr} + 1'b1) == {1'b0, iterations});
  // First FEED of a job comes straight from IDLE, before cfg is latched.
  assign px2_en   = (state == IDLE) ? cfg_is_max : is_max;
  assign busy     = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_feed   = 1'b0;
    fin_job   = 1'b0;
    case (state)
      IDLE: if (start && !cfg_bad && cfg_iterations != '0) begin
        state_nxt = FEED;
        go_feed   = 1'b1;
      end
      FEED: if (&fin) state_nxt = WAIT;
      WAIT: if (out_seen | out_hs) state_nxt = GAP;
      GAP: if (gap_end) begin
        if (last_itr) begin
          state_nxt = IDLE;
          fin_job   = 1'b1;
        end else begin
          state_nxt = FEED;
          go_feed   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en         <= '0;
      cnt        <= '0;
      beats      <= '0;
      iterations <= '0;
      is_max     <= 1'b0;
      itr        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      out_seen   <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        is_max     <= cfg_is_max;
        iterations <= cfg_iterations;
        beats[0]   <= cfg_beats_1;
        beats[1]   <= cfg_beats_1 - 1'b1;
        beats[2]   <= cfg_beats_w;
        itr        <= '0;
        cnt        <= '0;
        err        <= cfg_bad;
        if (cfg_bad || cfg_iterations == '0) done <= 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
          if (upl[i] != last[i]) err <= 1'b1;
          if (last[i]) en[i] <= 1'b0;
        end
      end
      if ((state == FEED || state == WAIT) && out_hs) out_seen <= 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (go_feed) begin
        en       <= {1'b1, px2_en, 1'b1};
        cnt      <= '0;
        out_seen <= 1'b0;
      end
      if (fin_job) done <= 1'b1;
      if (state == GAP && gap_end && !last_itr) itr <= itr + 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_input_scheduler.sv
// tb_axis_input_scheduler
//   Directed scenarios against a job-level model: per stream the model holds a
//   beat count and a target; a stream is open exactly while count < target.
//   A compare process checks every DUT output against the model each cycle;
//   literal expectations pin beat totals, done counts and gap timing.
module tb_axis_input_scheduler;
  localparam int GAP = 100;

  logic        aclk = 1'b0, aresetn = 1'b0, start = 1'b0, cfg_is_max = 1'b0;
  logic [7:0]  cfg_iterations = '0;
  logic [15:0] cfg_beats_1 = '0, cfg_beats_w = '0;
  logic [2:0]  upv = '0, upl = '0, dnr = '0, urdy, dval;
  logic        mv = 1'b0, mr = 1'b0, ml = 1'b0;
  logic        busy, done, err;
  logic [7:0]  itr;

  axis_input_scheduler #(.BEATS_W(16), .ITR_W(8), .GAP_CYCLES(GAP)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .cfg_is_max(cfg_is_max),
    .cfg_iterations(cfg_iterations), .cfg_beats_1(cfg_beats_1), .cfg_beats_w(cfg_beats_w),
    .up_px1_tvalid(upv[0]), .up_px1_tlast(upl[0]), .up_px1_tready(urdy[0]),
    .up_px2_tvalid(upv[1]), .up_px2_tlast(upl[1]), .up_px2_tready(urdy[1]),
    .up_w_tvalid(upv[2]),   .up_w_tlast(upl[2]),   .up_w_tready(urdy[2]),
    .dn_px1_tvalid(dval[0]), .dn_px1_tready(dnr[0]),
    .dn_px2_tvalid(dval[1]), .dn_px2_tready(dnr[1]),
    .dn_w_tvalid(dval[2]),   .dn_w_tready(dnr[2]),
    .m_axis_tvalid(mv), .m_axis_tready(mr), .m_axis_tlast(ml),
    .busy(busy), .done(done), .itr(itr), .err(err)
  );

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0;
  bit rnd = 0, inj = 0, chk_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  typedef enum int {M_IDLE, M_RUN, M_GAP} mm_t;
  mm_t m_mode;
  int  m_cnt[3], m_tgt[3], m_itr, m_iters, m_gap;
  bit  m_seen, m_err, m_done, m_cpl, m_hs;
  logic [2:0] en_exp;

  always_comb begin
    m_cpl = (m_cnt[0] == m_tgt[0]) && (m_cnt[1] == m_tgt[1]) && (m_cnt[2] == m_tgt[2]);
    m_hs  = mv & mr & ml;
    for (int x = 0; x < 3; x++) en_exp[x] = (m_cnt[x] < m_tgt[x]);
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_mode <= M_IDLE; m_itr <= 0; m_iters <= 0; m_gap <= 0;
      m_seen <= 0; m_err <= 0; m_done <= 0;
      for (int x = 0; x < 3; x++) begin m_cnt[x] <= 0; m_tgt[x] <= 0; end
    end else begin
      m_done <= 0;
      case (m_mode)
        M_IDLE: if (start) begin
          m_err <= 0; m_itr <= 0; m_seen <= 0; m_iters <= int'(cfg_iterations);
          for (int x = 0; x < 3; x++) begin m_cnt[x] <= 0; m_tgt[x] <= 0; end
          if (cfg_beats_1 == 0 || cfg_beats_w == 0 || (cfg_is_max && cfg_beats_1 == 1)) begin
            m_err <= 1; m_done <= 1;
          end else if (cfg_iterations == 0) begin
            m_done <= 1;
          end else begin
            m_mode   <= M_RUN;
            m_tgt[0] <= int'(cfg_beats_1);
            m_tgt[1] <= cfg_is_max ? int'(cfg_beats_1) - 1 : 0;
            m_tgt[2] <= int'(cfg_beats_w);
          end
        end
        M_RUN: begin
          for (int x = 0; x < 3; x++)
            if (upv[x] && dnr[x] && m_cnt[x] < m_tgt[x]) begin
              m_cnt[x] <= m_cnt[x] + 1;
              if (upl[x] != (m_cnt[x] == m_tgt[x] - 1)) m_err <= 1;
            end
          // Pipe-done only closes the iteration once all feeding finished earlier.
          if (m_cpl && (m_seen || m_hs)) begin
            m_mode <= M_GAP; m_gap <= GAP;
          end else if (m_hs) m_seen <= 1;
        end
        M_GAP: if (m_gap == 1) begin
          if (m_itr + 1 == m_iters) begin
            m_done <= 1; m_mode <= M_IDLE;
          end else begin
            m_itr <= m_itr + 1; m_seen <= 0; m_mode <= M_RUN;
            for (int x = 0; x < 3; x++) m_cnt[x] <= 0;
          end
        end else m_gap <= m_gap - 1;
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  // ---------------- observation ----------------
  int pass[3] = '{0, 0, 0};
  int done_cnt = 0, cyc = 0, hs_cyc = 0, done_cyc = 0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (m_hs) hs_cyc <= cyc + 1;
    for (int x = 0; x < 3; x++) if (upv[x] && urdy[x]) pass[x] <= pass[x] + 1;
  end

  always @(negedge aclk) begin
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (aresetn && chk_on) begin
      chk("busy", busy, m_mode != M_IDLE);
      chk("done", done, m_done);
      chk("itr", itr, m_itr);
      chk("err", err, m_err);
      for (int x = 0; x < 3; x++) begin
        chk($sformatf("dn_tvalid%0d", x), dval[x], upv[x] & en_exp[x]);
        chk($sformatf("up_tready%0d", x), urdy[x], dnr[x] & en_exp[x]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge aclk); #1;
    start = 1'b0;
    for (int x = 0; x < 3; x++) begin
      upv[x] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dnr[x] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      upl[x] = (m_cnt[x] == m_tgt[x] - 1) || (inj && x == 0 && m_cnt[0] == 4);
    end
    if (rnd) begin
      mv = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1)); ml = 1'($urandom_range(0, 1));
    end else begin
      mv = (m_mode == M_RUN) && m_cpl; mr = mv; ml = mv;
    end
  endtask

  task automatic do_start(input bit mx, input int b1, input int bw, input int it);
    cfg_is_max = mx; cfg_beats_1 = 16'(b1); cfg_beats_w = 16'(bw); cfg_iterations = 8'(it);
    start = 1'b1;
    step();
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget && m_mode != M_IDLE; i++) step();
    if (m_mode != M_IDLE) chk("job_timeout", 0, 1);
    step(); step();
  endtask

  int p0[3], d0;
  task automatic snap();
    for (int x = 0; x < 3; x++) p0[x] = pass[x];
    d0 = done_cnt;
  endtask
  task automatic chk_job(input string nm, input int a, input int b, input int c, input int nd);
    chk({nm, "_px1"}, pass[0] - p0[0], a);
    chk({nm, "_px2"}, pass[1] - p0[1], b);
    chk({nm, "_w"},   pass[2] - p0[2], c);
    chk({nm, "_done"}, done_cnt - d0, nd);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_itr", itr, 0);   chk("rst_en", {urdy, dval}, 0);
    aresetn = 1'b1; chk_on = 1;
    step();

    // Two iterations, single pixel stream, all valid/ready.
    snap(); do_start(0, 17, 20, 2); run_idle(1000);
    chk_job("basic", 34, 0, 40, 1);
    chk("basic_itr", itr, 1);
    chk("basic_gap", done_cyc - hs_cyc, GAP);

    // Second pixel stream; weight stream finishes last.
    snap(); do_start(1, 17, 30, 1); run_idle(1000);
    chk_job("max", 17, 16, 30, 1);

    // Random handshakes on all streams and on the monitor.
    rnd = 1; snap(); do_start(1, 9, 12, 2); run_idle(3000);
    chk_job("rand", 18, 16, 24, 1);
    chk("rand_err", err, 0);
    rnd = 0; step();

    // Early tlast on px1 beat 5: error flagged, job still completes.
    inj = 1; snap(); do_start(0, 17, 20, 1); run_idle(1000); inj = 0;
    chk_job("tlast", 17, 0, 20, 1);
    chk("tlast_err", err, 1);

    // Zero iterations: done on the next cycle, nothing passes, err cleared.
    snap(); do_start(0, 3, 3, 0);
    chk("zero_done", done, 1); chk("zero_busy", busy, 0); chk("zero_err", err, 0);
    step(); step();
    chk_job("zero", 0, 0, 0, 1);

    // Bad configurations flag err and finish immediately.
    do_start(1, 1, 5, 3);
    chk("bad1_err", err, 1); chk("bad1_done", done, 1);
    step();
    do_start(0, 4, 0, 3);
    chk("badw_err", err, 1); chk("badw_busy", busy, 0);
    step();

    // Start during GAP is ignored.
    snap(); do_start(0, 4, 4, 2);
    for (int i = 0; i < 200 && m_mode != M_GAP; i++) step();
    cfg_iterations = 8'd7; cfg_beats_1 = 16'd9; start = 1'b1; step();
    run_idle(1000);
    chk_job("gapstart", 8, 0, 8, 1);
    chk("gapstart_itr", itr, 1);

    // Reset in the middle of iteration 1 feeding.
    snap(); do_start(1, 6, 8, 2);
    for (int i = 0; i < 400 && !(m_itr == 1 && m_mode == M_RUN && m_cnt[0] >= 2); i++) step();
    chk("rst_reach", m_itr, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_itr", itr, 0); chk("arst_err", err, 0);
    chk("arst_done", done, 0); chk("arst_en", {urdy, dval}, 0);
    step(); step();
    aresetn = 1'b1;
    repeat (5) step();
    chk("arst_nodone", done_cnt - d0, 0);
    snap(); do_start(0, 5, 7, 1); run_idle(1000);
    chk_job("after_rst", 5, 0, 7, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
